io_responder: RTL and testbench

- Device-side end of the CPU memory/IO bridge.
- Decodes IO-space read/write strobes, address and write data, and serves the 16-bit IO read bus (switches, confirm status).
- Owns the confirm-button handshake: debounce, pending flag, CPU clear.
- Drives the LED register and a 4-digit multiplexed hex seven-segment display from CPU-written registers.

---
 rtl/io_map_pkg.sv | 37 +++
 rtl/io_debounce.sv | 50 +++++
 rtl/io_responder.sv | 112 +++++++++++
 tb/tb_io_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// IO address map and seven-segment cathode encoding shared by the IO responder.
package io_map_pkg;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned WDATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_LED     = 14'h3C60;
    localparam logic [ADDR_W-1:0] ADDR_SW      = 14'h3C70;
    localparam logic [ADDR_W-1:0] ADDR_CONFIRM = 14'h3C80;
    localparam logic [ADDR_W-1:0] ADDR_SEG     = 14'h3C90;

    // Active-low cathodes {dp, g, f, e, d, c, b, a}; dp is always off.
    function automatic logic [7:0] hex7seg(input logic [3:0] nib);
        logic [7:0] cat;
        case (nib)
            4'h0:    cat = 8'hC0;
            4'h1:    cat = 8'hF9;
            4'h2:    cat = 8'hA4;
            4'h3:    cat = 8'hB0;
            4'h4:    cat = 8'h99;
            4'h5:    cat = 8'h92;
            4'h6:    cat = 8'h82;
            4'h7:    cat = 8'hF8;
            4'h8:    cat = 8'h80;
            4'h9:    cat = 8'h90;
            4'hA:    cat = 8'h88;
            4'hB:    cat = 8'h83;
            4'hC:    cat = 8'hC6;
            4'hD:    cat = 8'hA1;
            4'hE:    cat = 8'h86;
            default: cat = 8'h8E;
        endcase
        return cat;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus hold-time debouncer with a one-cycle rising-edge pulse.
module io_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Count consecutive cycles of disagreement; flip the level once the hold time is met.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/io_responder.sv
// Device-side IO responder: register decode, confirm handshake, LEDs and hex display scan.
module io_responder
    import io_map_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  io_addr,
    input  logic [WDATA_W-1:0] io_wdata,
    input  logic               io_write,
    input  logic               io_read,
    output logic [DATA_W-1:0]  io_rdata,
    output logic               confirm_o,
    input  logic [DATA_W-1:0]  sw,
    input  logic               btn_confirm,
    output logic [DATA_W-1:0]  led,
    output logic [3:0]         seg_an,
    output logic [7:0]         seg_cat
);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DATA_W-1:0] sw_meta_q, sw_sync_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        cat_q, cat_d;
    logic              btn_rise;
    logic              deb_level_unused;
    logic              wdata_hi_unused;
    logic              wrap;

    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_confirm_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_confirm),
        .level (deb_level_unused),
        .rise  (btn_rise)
    );

    assign wdata_hi_unused = ^io_wdata[WDATA_W-1:DATA_W];

    always_comb begin
        rdata_d   = rdata_q;
        pending_d = pending_q;
        led_d     = led_q;
        disp_d    = disp_q;

        // Reads sample pre-write state, so a same-cycle write never leaks into the read.
        if (io_read) begin
            case (io_addr)
                ADDR_SW:      rdata_d = sw_sync_q;
                ADDR_CONFIRM: rdata_d = DATA_W'(pending_q);
                default:      rdata_d = '0;
            endcase
        end

        if (io_write && io_addr == ADDR_LED) led_d  = io_wdata[DATA_W-1:0];
        if (io_write && io_addr == ADDR_SEG) disp_d = io_wdata[DATA_W-1:0];

        // A fresh press outranks a simultaneous CPU clear.
        if (btn_rise) begin
            pending_d = 1'b1;
        end else if (io_write && io_addr == ADDR_CONFIRM) begin
            pending_d = 1'b0;
        end

        wrap   = (scan_q == SCAN_W'(SCAN_DIV - 1));
        scan_d = wrap ? '0 : scan_q + SCAN_W'(1);
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;
        an_d   = wrap ? (4'b1111 ^ (4'b0001 << idx_d)) : an_q;
        cat_d  = (an_d != 4'b1111) ? hex7seg(disp_d[{idx_d, 2'b00} +: 4]) : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= '0;
            pending_q <= 1'b0;
            led_q     <= '0;
            disp_q    <= '0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            cat_q     <= 8'hFF;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            disp_q    <= disp_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            cat_q     <= cat_d;
        end
    end

    assign io_rdata  = rdata_q;
    assign confirm_o = pending_q;
    assign led       = led_q;
    assign seg_an    = an_q;
    assign seg_cat   = cat_q;

endmodule

// File: tb/tb_io_responder.sv
// Randomized self-checking bench for io_responder against a cycle-level behavioural model.
module tb_io_responder;
    localparam int unsigned DEB  = 4;
    localparam int unsigned SCAN = 8;
    localparam logic [13:0] A_LED  = 14'h3C60;
    localparam logic [13:0] A_SW   = 14'h3C70;
    localparam logic [13:0] A_CONF = 14'h3C80;
    localparam logic [13:0] A_SEG  = 14'h3C90;

    logic        clk;
    logic        rst_n;
    logic [13:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_write;
    logic        io_read;
    logic [15:0] io_rdata;
    logic        confirm_o;
    logic [15:0] sw;
    logic        btn_confirm;
    logic [15:0] led;
    logic [3:0]  seg_an;
    logic [7:0]  seg_cat;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] seg_tab [16];

    // Model state
    logic [15:0] m_s1, m_s2;
    logic        m_b1, m_b2, m_lvl, m_rise, m_pend;
    int          m_run, m_edges;
    logic [15:0] m_led, m_disp, m_rdata;

    io_responder #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .io_write    (io_write),
        .io_read     (io_read),
        .io_rdata    (io_rdata),
        .confirm_o   (confirm_o),
        .sw          (sw),
        .btn_confirm (btn_confirm),
        .led         (led),
        .seg_an      (seg_an),
        .seg_cat     (seg_cat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_b1 = 0; m_b2 = 0; m_lvl = 0; m_rise = 0; m_pend = 0;
            m_run = 0; m_edges = 0; m_led = '0; m_disp = '0; m_rdata = '0;
        end else begin
            if (io_read)
                m_rdata = (io_addr == A_SW) ? m_s2 : (io_addr == A_CONF) ? {15'b0, m_pend} : 16'h0000;
            if (m_rise) m_pend = 1'b1;
            else if (io_write && io_addr == A_CONF) m_pend = 1'b0;
            if (io_write && io_addr == A_LED) m_led  = io_wdata[15:0];
            if (io_write && io_addr == A_SEG) m_disp = io_wdata[15:0];
            // Level flips once the synchronized button has disagreed for DEB straight cycles.
            if (m_b2 != m_lvl) begin
                m_run++;
                if (m_run == DEB) begin
                    m_lvl  = ~m_lvl;
                    m_rise = m_lvl;
                    m_run  = 0;
                end else begin
                    m_rise = 1'b0;
                end
            end else begin
                m_run  = 0;
                m_rise = 1'b0;
            end
            m_s2 = m_s1; m_s1 = sw;
            m_b2 = m_b1; m_b1 = btn_confirm;
            m_edges++;
        end
    endtask

    // Compare every cycle; display state follows from the number of completed scan periods.
    initial begin : compare
        int w;
        logic [3:0] exp_an;
        logic [7:0] exp_cat;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            w = m_edges / SCAN;
            if (w == 0) begin
                exp_an  = 4'b1111;
                exp_cat = 8'hFF;
            end else begin
                exp_an  = 4'b1111 ^ (4'b0001 << (w % 4));
                exp_cat = seg_tab[m_disp[(w % 4) * 4 +: 4]];
            end
            chk("io_rdata", 32'(io_rdata), 32'(m_rdata));
            chk("confirm_o", 32'(confirm_o), 32'(m_pend));
            chk("led", 32'(led), 32'(m_led));
            chk("seg_an", 32'(seg_an), 32'(exp_an));
            chk("seg_cat", 32'(seg_cat), 32'(exp_cat));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [13:0] a);
        io_addr = a; io_read = 1'b1;
        tick();
        io_read = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        io_addr = a; io_wdata = d; io_write = 1'b1;
        tick();
        io_write = 1'b0;
    endtask

    initial begin : stim
        logic found;
        int   n_e, n_d, n_b, n_7, n_other;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_write = 1'b0; io_read = 1'b0;
        sw = '0; btn_confirm = 1'b0;
        idle(3);
        chk("rst_rdata", 32'(io_rdata), 32'h0);
        chk("rst_confirm", 32'(confirm_o), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_an", 32'(seg_an), 32'hF);
        chk("rst_cat", 32'(seg_cat), 32'hFF);
        rst_n = 1'b1;
        rd(A_CONF);
        chk("rd_conf_idle", 32'(io_rdata), 32'h0000);

        sw = 16'hA5C3;
        idle(3);
        rd(A_SW);
        chk("rd_sw", 32'(io_rdata), 32'hA5C3);
        idle(2);
        chk("rdata_hold", 32'(io_rdata), 32'hA5C3);
        rd(14'h3C00);
        chk("rd_unmapped", 32'(io_rdata), 32'h0000);

        btn_confirm = 1'b1; idle(3); btn_confirm = 1'b0; idle(10);
        chk("short_press", 32'(confirm_o), 32'h0);

        btn_confirm = 1'b1; idle(12);
        chk("long_press", 32'(confirm_o), 32'h1);
        rd(A_CONF);
        chk("rd_conf_set", 32'(io_rdata), 32'h0001);

        wr(A_CONF, $urandom);
        chk("clear", 32'(confirm_o), 32'h0);
        idle(10);
        chk("hold_no_reset", 32'(confirm_o), 32'h0);
        btn_confirm = 1'b0; idle(10);

        // Line up a clear write with the edge where the debounced rise lands.
        btn_confirm = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_rise) begin
                found = 1'b1;
                wr(A_CONF, 32'h0);
            end else begin
                tick();
            end
        end
        chk("coincide_found", 32'(found), 32'h1);
        chk("set_wins", 32'(confirm_o), 32'h1);
        idle(2);
        btn_confirm = 1'b0; idle(10);

        wr(A_SEG, 32'h0000_1234);
        wr(A_LED, 32'h0000_BEEF);
        chk("led_beef", 32'(led), 32'hBEEF);
        n_e = 0; n_d = 0; n_b = 0; n_7 = 0; n_other = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            case (seg_an)
                4'b1110: begin n_e++; chk("digit0", 32'(seg_cat), 32'h99); end
                4'b1101: begin n_d++; chk("digit1", 32'(seg_cat), 32'hB0); end
                4'b1011: begin n_b++; chk("digit2", 32'(seg_cat), 32'hA4); end
                4'b0111: begin n_7++; chk("digit3", 32'(seg_cat), 32'hF9); end
                default: n_other++;
            endcase
        end
        chk("slot0_len", 32'(n_e), 32'd8);
        chk("slot1_len", 32'(n_d), 32'd8);
        chk("slot2_len", 32'(n_b), 32'd8);
        chk("slot3_len", 32'(n_7), 32'd8);
        chk("an_other", 32'(n_other), 32'd0);

        // Reset in the middle of a press: a full new debounce is needed afterwards.
        btn_confirm = 1'b1; idle(3);
        rst_n = 1'b0; tick();
        chk("midpress_rst_conf", 32'(confirm_o), 32'h0);
        chk("midpress_rst_an", 32'(seg_an), 32'hF);
        rst_n = 1'b1; idle(3);
        chk("midpress_early", 32'(confirm_o), 32'h0);
        idle(9);
        chk("midpress_after", 32'(confirm_o), 32'h1);
        btn_confirm = 1'b0; idle(10);

        for (int i = 0; i < 800; i++) begin
            rst_n    = ($urandom_range(0, 249) != 0);
            io_read  = ($urandom_range(0, 2) == 0);
            io_write = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       io_addr = A_LED;
                1:       io_addr = A_SW;
                2:       io_addr = A_CONF;
                3:       io_addr = A_SEG;
                default: io_addr = 14'($urandom);
            endcase
            io_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            if ($urandom_range(0, 9) == 0) btn_confirm = ~btn_confirm;
            tick();
        end
        rst_n = 1'b1; io_read = 1'b0; io_write = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
